serial_subtractor: RTL

Bit-serial N-bit subtractor that computes A - B one bit per clock, LSB first, with a single full-subtractor cell and a registered borrow. It is the inverse-direction companion to the team's combinational 1-bit adder cell. It sits in the mylib arithmetic library as an area-minimal datapath element. Operands are accepted and results returned over valid/ready handshakes.

---
 rtl/serial_subtractor.sv | 86 ++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A-B, LSB first, one full-subtractor cell and a registered borrow.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             w_x, w_y, w_d, w_bo, w_last;
  assign w_x    = r_a[0];
  assign w_y    = r_b[0];
  assign w_d    = w_x ^ w_y ^ r_borrow;
  assign w_bo   = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign diff   = r_diff;
  assign borrow = r_borrow;
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        w_next   = in_valid ? RUN : IDLE;
      end
      RUN:  w_next = w_last ? DONE : RUN;
      DONE: begin
        out_valid = 1'b1;
        w_next    = out_ready ? IDLE : DONE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_diff   <= {w_d, r_diff[WIDTH-1:1]};
      r_borrow <= w_bo;
      r_cnt    <= r_cnt + CW'(1);
    end
  end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic r_ovf;
  // On the last bit x and y are the latched operand MSBs and d is the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_ovf <= 1'b0;
    else if (r_state == RUN && w_last) r_ovf <= (w_x ^ w_y) & (w_d ^ w_x);
  end
  assign ovf = r_ovf;
`endif
endmodule
